// File: rtl/syn_hazard_resolver_pkg.sv
// Shared types and helpers for the hazard resolver: bypass-select encoding
// and the per-operand forward priority rule.
package syn_hazard_resolver_pkg;

  localparam int unsigned FWD_W = 2;

  // Operand bypass mux select.
  typedef enum logic [FWD_W-1:0] {
    FWD_REG     = 2'b00,  // register file value
    FWD_EX      = 2'b01,  // EX-stage ALU result
    FWD_DM_ALU  = 2'b10,  // DM-stage ALU result
    FWD_DM_LOAD = 2'b11   // DM-stage load data
  } fwd_sel_e;

  // Youngest producer wins: EX beats DM; unused or stalled operands read the RF.
  function automatic fwd_sel_e fwd_select(
    input logic uses,
    input logic stalled,
    input logic ex_col,
    input logic dm_col,
    input logic dm_is_load
  );
    fwd_sel_e sel;
    sel = FWD_REG;
    if (!uses || stalled) begin
      sel = FWD_REG;
    end else if (ex_col) begin
      sel = FWD_EX;
    end else if (dm_col) begin
      sel = dm_is_load ? FWD_DM_LOAD : FWD_DM_ALU;
    end
    return sel;
  endfunction

endpackage

// File: rtl/syn_hazard_resolver_if.sv
// Bundle between the collision detector / ID stage and the hazard resolver.
//   master: drives collision flags, ID attributes, en, perf_clr
//   slave : drives stalled, fwd_sel_a/b and the performance counters
interface syn_hazard_resolver_if
  import syn_hazard_resolver_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);

  logic             en;
  logic             ex_collision_a;
  logic             dm_collision_a;
  logic             ex_collision_b;
  logic             dm_collision_b;
  logic             id_uses_a;
  logic             id_uses_b;
  logic             id_mem_read;
  logic             perf_clr;
  logic             stalled;
  fwd_sel_e         fwd_sel_a;
  fwd_sel_e         fwd_sel_b;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] fwd_events;

  modport master (
    output en, ex_collision_a, dm_collision_a, ex_collision_b, dm_collision_b,
           id_uses_a, id_uses_b, id_mem_read, perf_clr,
    input  stalled, fwd_sel_a, fwd_sel_b, stall_cycles, fwd_events
  );

  modport slave (
    input  en, ex_collision_a, dm_collision_a, ex_collision_b, dm_collision_b,
           id_uses_a, id_uses_b, id_mem_read, perf_clr,
    output stalled, fwd_sel_a, fwd_sel_b, stall_cycles, fwd_events
  );

endinterface

// File: rtl/syn_hazard_resolver_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear
//   inc        : increment request, ignored once all-ones
//   q          : count
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/syn_hazard_resolver.sv
// ID-stage hazard resolver: chooses operand forwarding vs a one-cycle
// load-use stall, tracks loads in EX/DM, and counts stalls/forwards.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of syn_hazard_resolver_if (collision flags and
//                ID attributes in; stalled, bypass selects, counters out)
module syn_hazard_resolver
  import syn_hazard_resolver_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  syn_hazard_resolver_if.slave  bus
);

  logic     r_ex_is_load;
  logic     r_dm_is_load;
  logic     w_use_a;
  logic     w_use_b;
  logic     w_stalled;
  fwd_sel_e w_sel_a;
  fwd_sel_e w_sel_b;
  logic     w_fwd_any;
  logic     w_stall_inc;
  logic     w_fwd_inc;
  logic     w_clr;

  // Stall and bypass selection, all same-cycle.
  always_comb begin
    w_use_a   = bus.ex_collision_a & bus.id_uses_a;
    w_use_b   = bus.ex_collision_b & bus.id_uses_b;
    w_stalled = bus.en & r_ex_is_load & (w_use_a | w_use_b);
    w_sel_a   = fwd_select(bus.id_uses_a, w_stalled, bus.ex_collision_a,
                           bus.dm_collision_a, r_dm_is_load);
    w_sel_b   = fwd_select(bus.id_uses_b, w_stalled, bus.ex_collision_b,
                           bus.dm_collision_b, r_dm_is_load);
    w_fwd_any = (w_sel_a != FWD_REG) | (w_sel_b != FWD_REG);
  end

  // Load flags follow the destination-register pipeline; a stall injects a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_is_load <= 1'b0;
      r_dm_is_load <= 1'b0;
    end else if (bus.en) begin
      r_ex_is_load <= w_stalled ? 1'b0 : bus.id_mem_read;
      r_dm_is_load <= r_ex_is_load;
    end
  end

  // Counters only move on pipeline advance.
  assign w_clr       = bus.en & bus.perf_clr;
  assign w_stall_inc = bus.en & w_stalled;
  assign w_fwd_inc   = bus.en & w_fwd_any;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_stall_inc),
    .q     (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_fwd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_fwd_inc),
    .q     (bus.fwd_events)
  );

  assign bus.stalled   = w_stalled;
  assign bus.fwd_sel_a = w_sel_a;
  assign bus.fwd_sel_b = w_sel_b;

endmodule

// File: doc/syn_hazard_resolver.md
Name: syn_hazard_resolver

Overview:
Consumer side of the pipeline data-collision flags. It takes per-operand EX/DM collision indications plus ID-stage instruction attributes and decides, each cycle, between operand forwarding and a one-cycle load-use stall. It tracks which in-flight instructions are loads and drives the `stalled` signal back to the collision detector. It sits in the ID stage beside the collision detector, driving the operand bypass muxes and the PC/IF-ID hold logic, and keeps saturating performance counters.

Parameters:
CNT_W, 32, width of the stall-cycle and forward-event performance counters.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  pipeline advance enable; low freezes all state.
ex_collision_a  in  1  operand A matches the EX-stage destination register (non-zero).
dm_collision_a  in  1  operand A matches the DM-stage destination register.
ex_collision_b  in  1  operand B matches the EX-stage destination register.
dm_collision_b  in  1  operand B matches the DM-stage destination register.
id_uses_a  in  1  ID instruction actually reads operand A.
id_uses_b  in  1  ID instruction actually reads operand B.
id_mem_read  in  1  ID instruction is a load that writes the register file.
perf_clr  in  1  synchronous clear of both counters.
stalled  out  1  load-use stall: hold PC and IF/ID, inject a bubble into EX.
fwd_sel_a  out  2  operand A bypass select.
fwd_sel_b  out  2  operand B bypass select.
stall_cycles  out  CNT_W  saturating count of stall cycles.
fwd_events  out  CNT_W  saturating count of cycles with any non-register forward.

Behaviour:
Interface decision: one clock `clk`; reset `rst_n` is asynchronous and active-low.

Reset:
- ex_is_load, dm_is_load, stall_cycles and fwd_events are cleared to 0.
- stalled = 0; fwd_sel_a and fwd_sel_b = FWD_REG.

Load tracking registers (same advance rules as the destination-register pipeline):
- en low: hold.
- en high and stalled: ex_is_load <= 0 (bubble); dm_is_load <= ex_is_load.
- Otherwise: ex_is_load <= id_mem_read; dm_is_load <= ex_is_load.

Stall (combinational, same cycle):
- use_a = ex_collision_a & id_uses_a; use_b = ex_collision_b & id_uses_b.
- stalled = en & ex_is_load & (use_a | use_b).
- A stall lasts exactly one cycle. The bubble clears ex_is_load, the load moves to DM, and the next cycle forwards FWD_DM_LOAD.
- Back-to-back loads with dependencies each stall once.

Forward select per operand X (combinational; priority order):
- X unused or stalled: FWD_REG.
- ex_collision_X: FWD_EX (ALU result).
- dm_collision_X: FWD_DM_LOAD if dm_is_load, else FWD_DM_ALU.
- Otherwise: FWD_REG.
- EX beats DM when both collide, so the youngest producer wins.

Counters (advance only when en high; perf_clr takes precedence over increment):
- stall_cycles increments on stalled.
- fwd_events increments when either select is not FWD_REG.
- Both saturate at all-ones and do not wrap.

Other rules:
- en low: stalled forced 0, all registers hold, selects still computed.
- Reset asserted mid-stall drops stalled immediately (asynchronous).

Decomposition:
- Shared package holds the 2-bit select constants: FWD_REG=00, FWD_EX=01, FWD_DM_ALU=10, FWD_DM_LOAD=11.
- One sub-module: sat_counter (parameter W; ports clk, rst_n, clr, inc, q), instantiated twice.

Test Plan:
- ALU write r5 then dependent reader of r5 on A (ex_collision_a=1, id_uses_a=1, ex_is_load=0) -> stalled=0, fwd_sel_a=01, fwd_events=1.
- Load r7 (id_mem_read=1) then next instruction reads r7 on B -> cycle 1: stalled=1, fwd_sel_b=00, stall_cycles=1. Cycle 2 (dm_collision_b=1, ex_collision_b=0): stalled=0, fwd_sel_b=11.
- ex_collision_a=1 and dm_collision_a=1 together, non-load -> fwd_sel_a=01. Same with id_uses_a=0 -> fwd_sel_a=00.
- en=0 during a pending load-use -> stalled=0, ex_is_load/dm_is_load and counters unchanged. en=1 next cycle -> stall asserted.
- CNT_W=4: 20 consecutive stall cycles -> stall_cycles saturates at 15. perf_clr coincident with stall -> counter reads 0 next cycle.
- rst_n pulsed low while stalled=1 -> stalled=0 immediately; all state and counters read 0.
